// File: rtl/qpmm_result_drain.sv
// ---------------------------------------------------------------------------
// qpmm_result_drain
//
// Egress stage of the fixed-latency QPMM multiplier pipeline. The pipeline
// has no stall, so this block does three things:
//   * It grants the issuer credit so that results can never overflow the
//     local buffer.
//   * It captures each Z into a FIFO exactly PIPE_LAT cycles after its
//     operands were accepted.
//   * It fully reduces each Z into [0,P) by repeated subtraction and hands
//     results out in issue order on a ready/valid port.
//
// Optional feature macro: QPMM_DRAIN_TAG_EN
//   When defined, a TAG_W-bit tag rides along with every token
//   (tag_in -> tag_out). When undefined, there are no tag ports and no tag
//   storage.
//
// Ports
//   clk        in   1      clock, all logic on posedge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operands issued this cycle (counted only if in_ready)
//   in_ready   out  1      issuer may issue (credit available)
//   z_in       in   W_Z    QPMM result, sampled when a tracked token emerges
//   out_valid  out  1      out_data holds a reduced result
//   out_ready  in   1      consumer accepts (transfer = out_valid & out_ready)
//   out_data   out  W_Z    reduced result in [0,P)
//   err_ovf    out  1      sticky: in_valid seen while in_ready was low
//   err_range  out  1      sticky: value still >= P after MAX_SUB subtractions
//   tag_in     in   TAG_W  (QPMM_DRAIN_TAG_EN) tag sampled with in_valid
//   tag_out    out  TAG_W  (QPMM_DRAIN_TAG_EN) tag aligned with out_data
// ---------------------------------------------------------------------------
module qpmm_result_drain #(
    parameter int W_Z        = 272,
    parameter logic [W_Z-1:0] P = W_Z'(256'h2523648240000001BA344D80000000086121000000000013A700000000000013),
    parameter int PIPE_LAT   = 56,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_SUB    = 3,
    parameter int TAG_W      = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W_Z-1:0] z_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W_Z-1:0] out_data,
    output logic           err_ovf,
    output logic           err_range
`ifdef QPMM_DRAIN_TAG_EN
    ,
    input  logic [TAG_W-1:0] tag_in,
    output logic [TAG_W-1:0] tag_out
`endif
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int SUB_W = $clog2(MAX_SUB + 1);
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [SUB_W-1:0] MAX_SUB_L = SUB_W'(MAX_SUB);

    // Elaboration-time sanity checks on the configuration.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (PIPE_LAT < 2) begin : g_bad_lat
        $error("PIPE_LAT must be at least 2");
    end
    if (MAX_SUB < 1) begin : g_bad_sub
        $error("MAX_SUB must be at least 1");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("TAG_W must be at least 1");
    end

    // ------------------------------------------------------------------
    // Token delay line and in-flight credit counter
    // ------------------------------------------------------------------
    logic [PIPE_LAT-1:0] tok_reg;
    logic [CNT_W-1:0]    inflight_reg;
    logic                accept;
    logic                emerge;

    assign accept = in_valid & in_ready;
    assign emerge = tok_reg[PIPE_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            tok_reg <= '0;
        end else begin
            tok_reg <= {tok_reg[PIPE_LAT-2:0], accept};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg <= '0;
        end else begin
            case ({accept, emerge})
                2'b10:   inflight_reg <= inflight_reg + CNT_W'(1);
                2'b01:   inflight_reg <= inflight_reg - CNT_W'(1);
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO (array storage, read captured straight into the work reg)
    // ------------------------------------------------------------------
    logic [W_Z-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push;
    logic             pop;
    logic             fifo_empty;

    assign push       = emerge;
    assign fifo_empty = (count_reg == '0);

    // Every token already counted (in flight or buffered) owns a FIFO slot,
    // so a push can never find the FIFO full.
    assign in_ready = ({1'b0, inflight_reg} + {1'b0, count_reg}) < DEPTH_L;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= z_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Reduction FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [W_Z-1:0]   r_reg;
    logic [SUB_W-1:0] cnt_reg;
    logic [W_Z:0]     diff;
    logic             r_ge_p;
    logic             do_sub;
    logic             load_out;
    logic             set_range;
    logic             clear_valid;
    logic             out_valid_reg;
    logic [W_Z-1:0]   out_data_reg;
    logic             err_ovf_reg;
    logic             err_range_reg;

    // One extra bit so the borrow tells us r < P; the difference is only
    // committed when there is no borrow, so it never wraps.
    assign diff   = {1'b0, r_reg} - {1'b0, P};
    assign r_ge_p = ~diff[W_Z];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pop         = 1'b0;
        do_sub      = 1'b0;
        load_out    = 1'b0;
        set_range   = 1'b0;
        clear_valid = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = S_CMP;
                end
            end
            S_CMP: begin
                if (r_ge_p && (cnt_reg < MAX_SUB_L)) begin
                    do_sub = 1'b1;
                end else begin
                    // Either fully reduced, or out of subtraction budget.
                    load_out   = 1'b1;
                    set_range  = r_ge_p;
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    clear_valid = 1'b1;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = S_CMP;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg         <= '0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            err_range_reg <= 1'b0;
        end else begin
            if (pop) begin
                r_reg   <= mem[rd_ptr_reg];
                cnt_reg <= '0;
            end else if (do_sub) begin
                r_reg   <= diff[W_Z-1:0];
                cnt_reg <= cnt_reg + SUB_W'(1);
            end
            if (clear_valid) begin
                out_valid_reg <= 1'b0;
            end
            if (load_out) begin
                out_data_reg  <= r_reg;
                out_valid_reg <= 1'b1;
            end
            if (set_range) begin
                err_range_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_reg <= 1'b0;
        end else if (in_valid && !in_ready) begin
            err_ovf_reg <= 1'b1;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign err_ovf   = err_ovf_reg;
    assign err_range = err_range_reg;

`ifdef QPMM_DRAIN_TAG_EN
    // ------------------------------------------------------------------
    // Tag path: mirrors the token through delay line, FIFO and FSM.
    // Tags need no reset of their own; the token bits decide validity.
    // ------------------------------------------------------------------
    logic [TAG_W-1:0] tag_dly_reg [PIPE_LAT];
    logic [TAG_W-1:0] tag_mem [FIFO_DEPTH];
    logic [TAG_W-1:0] tag_r_reg;
    logic [TAG_W-1:0] tag_out_reg;

    for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_tag_dly
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                tag_dly_reg[gi] <= tag_in;
            end
        end else begin : g_body
            always_ff @(posedge clk) begin
                tag_dly_reg[gi] <= tag_dly_reg[gi-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_reg] <= tag_dly_reg[PIPE_LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_r_reg   <= '0;
            tag_out_reg <= '0;
        end else begin
            if (pop) begin
                tag_r_reg <= tag_mem[rd_ptr_reg];
            end
            if (load_out) begin
                tag_out_reg <= tag_r_reg;
            end
        end
    end

    assign tag_out = tag_out_reg;
`endif

endmodule

// File: tb/tb_qpmm_result_drain.sv
// ---------------------------------------------------------------------------
// tb_qpmm_result_drain
//
// Scoreboard bench for qpmm_result_drain. Each accepted issue schedules its
// Z value PIPE_LAT cycles ahead and pushes the reduced result (and tag) onto
// a queue; a monitor pops and compares on every output transfer.
// Build with QPMM_DRAIN_TAG_EN defined to also check tag_out.
// ---------------------------------------------------------------------------
module tb_qpmm_result_drain;

    localparam int PIPE_LAT = 56;
    localparam logic [271:0] P = 272'h2523648240000001BA344D80000000086121000000000013A700000000000013;

    typedef struct packed {
        logic [7:0]   tag;
        logic [271:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [271:0] z_in;
    logic         out_valid;
    logic         out_ready;
    logic [271:0] out_data;
    logic         err_ovf;
    logic         err_range;
`ifdef QPMM_DRAIN_TAG_EN
    logic [7:0]   tag_in;
    logic [7:0]   tag_out;
`endif

    int           vectors     = 0;
    int           miscompares = 0;
    int           cyc         = 0;
    int           n_xfer      = 0;
    logic [271:0] zsched [64];
    exp_t         sb [$];

    qpmm_result_drain dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_ovf   (err_ovf),
        .err_range (err_range)
`ifdef QPMM_DRAIN_TAG_EN
        ,
        .tag_in    (tag_in),
        .tag_out   (tag_out)
`endif
    );

    initial forever #5 clk = ~clk;

    task automatic check_val(input string name, input logic [271:0] got, input logic [271:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [271:0] reduce(input logic [271:0] z);
        logic [271:0] r;
        r = z;
        for (int n = 0; n < 3; n++) begin
            if (r >= P) r = r - P;
        end
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the following cycle.
    task automatic issue_one(input logic [271:0] z, input logic [7:0] tg,
                             output logic acc, output int c);
        exp_t e;
        in_valid = 1'b1;
`ifdef QPMM_DRAIN_TAG_EN
        tag_in = tg;
`endif
        @(negedge clk);
        acc = in_ready;
        c   = cyc;
        if (acc) begin
            zsched[(c + PIPE_LAT) % 64] = z;
            e.tag  = tg;
            e.data = reduce(z);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Issue one token with the output side idle and measure issue-to-valid.
    // Z is sampled PIPE_LAT cycles after issue, the FIFO is non-empty one
    // cycle later, and out_valid follows two cycles after that, plus one
    // cycle for every subtraction.
    task automatic lat_test(input string name, input logic [271:0] z,
                            input int nsub, input logic [7:0] tg);
        logic acc;
        int   c0;
        int   n;
        issue_one(z, tg, acc, c0);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        check_val(name, 272'(cyc - c0), 272'(PIPE_LAT + 3 + nsub));
        step(3);
    endtask

    task automatic drain(input string name, input int maxcyc, input logic rand_ready);
        int n;
        n = 0;
        while (sb.size() > 0 && n < maxcyc) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step(1);
            n++;
        end
        out_ready = 1'b1;
        step(2);
        check_val(name, 272'(sb.size()), 272'(0));
    endtask

    // z_in driver: presents the scheduled value in the cycle a token emerges.
    initial begin
        z_in = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            z_in = zsched[cyc % 64];
        end
    end

    // Output monitor / scoreboard pop.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
            end else if (out_valid && out_ready) begin
                n_xfer++;
                if (sb.size() == 0) begin
                    check_val("extra_result", 272'(out_valid), 272'(0));
                end else begin
                    e = sb.pop_front();
`ifdef QPMM_DRAIN_TAG_EN
                    $display("xfer %0d cyc %0d data=%0h tag=%0h", n_xfer, cyc, out_data, tag_out);
                    check_val("tag_out", 272'(tag_out), 272'(e.tag));
`else
                    $display("xfer %0d cyc %0d data=%0h", n_xfer, cyc, out_data);
`endif
                    check_val("out_data", out_data, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic         acc;
        int           c;
        int           x0;
        logic [271:0] z;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef QPMM_DRAIN_TAG_EN
        tag_in    = '0;
`endif
        for (int i = 0; i < 64; i++) zsched[i] = '0;

        // Reset state
        step(3);
        @(negedge clk);
        check_val("rst_in_ready",  272'(in_ready),  272'(1));
        check_val("rst_out_valid", 272'(out_valid), 272'(0));
        check_val("rst_out_data",  out_data,        272'(0));
        check_val("rst_err_ovf",   272'(err_ovf),   272'(0));
        check_val("rst_err_range", 272'(err_range), 272'(0));
`ifdef QPMM_DRAIN_TAG_EN
        check_val("rst_tag_out",   272'(tag_out),   272'(0));
`endif
        step(1);
        rst       = 1'b0;
        out_ready = 1'b1;
        step(2);

        // Latency and subtraction cases
        lat_test("lat_plain", 272'(5), 0, 8'hB1);
        lat_test("lat_sub1", P + 272'(7), 1, 8'hB2);
        lat_test("lat_sub2", P + P + 272'(1), 2, 8'hB3);
        @(negedge clk);
        check_val("err_ovf_clean",   272'(err_ovf),   272'(0));
        check_val("err_range_clean", 272'(err_range), 272'(0));
        step(1);
        lat_test("lat_range", P + P + P + P, 3, 8'hB4);
        @(negedge clk);
        check_val("err_range_set", 272'(err_range), 272'(1));
        step(1);

        // Backpressure: credit exhaustion and overflow flag
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            issue_one(272'(i), 8'hC0 + 8'(i), acc, c);
            check_val("bp_in_ready", 272'(acc), 272'(i < 8));
        end
        @(negedge clk);
        check_val("bp_err_ovf", 272'(err_ovf), 272'(1));
        step(PIPE_LAT + 10);
        @(negedge clk);
        check_val("bp_hold_valid", 272'(out_valid), 272'(1));
        check_val("bp_hold_data",  out_data,        272'(0));
        check_val("err_range_sticky", 272'(err_range), 272'(1));
        step(1);
        x0 = n_xfer;
        drain("bp_drain", 100, 1'b0);
        check_val("bp_count", 272'(n_xfer - x0), 272'(8));

        // Tags issued with stalls, consumer stalling at random
        issue_one(272'(11), 8'hA1, acc, c);
        step(2);
        issue_one(272'(12), 8'hA2, acc, c);
        step(1);
        issue_one(272'(13), 8'hA3, acc, c);
        drain("tag_drain", 300, 1'b1);

        // Random values needing 0..2 subtractions, random consumer stalls
        for (int i = 0; i < 6; i++) begin
            z = P * 272'($urandom_range(0, 2)) + 272'($urandom);
            issue_one(z, 8'hD0 + 8'(i), acc, c);
            step($urandom_range(0, 3));
        end
        drain("rand_drain", 300, 1'b1);

        // Reset mid-flight: some tokens buffered, some still in the pipe
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue_one(272'(100 + i), 8'hE0, acc, c);
        step(20);
        for (int i = 0; i < 4; i++) issue_one(272'(200 + i), 8'hE1, acc, c);
        step(35);
        @(negedge clk);
        check_val("mid_pre_valid", 272'(out_valid), 272'(1));
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check_val("mid_out_valid", 272'(out_valid), 272'(0));
        check_val("mid_in_ready",  272'(in_ready),  272'(1));
        check_val("mid_out_data",  out_data,        272'(0));
        check_val("mid_err_ovf",   272'(err_ovf),   272'(0));
        check_val("mid_err_range", 272'(err_range), 272'(0));
        step(1);
        x0 = n_xfer;
        out_ready = 1'b1;
        step(80);
        check_val("mid_no_output", 272'(n_xfer - x0), 272'(0));

        // Fresh traffic after the reset still works
        lat_test("lat_after_rst", 272'(9), 0, 8'hF1);
        drain("final_drain", 20, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
